// File: rtl/hc595.sv
// Serial-in shift register with storage latch, frame counter and tri-state parallel output.
// One bit per CP edge, no wait states; Q and its Z state follow STR/OE_N combinationally.
module hc595 #(
   parameter int WIDTH      = 8,
   parameter bit AUTO_LATCH = 1'b0
) (
   input  logic                     CP,
   input  logic                     RD,
   input  logic                     DS,
   input  logic                     SH_EN,
   input  logic                     ST_EN,
   input  logic                     OE_N,
   output logic [WIDTH-1:0]         Q,
   output logic                     QS,
   output logic [$clog2(WIDTH)-1:0] CNT,
   output logic                     FRAME
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] str;
   logic [WIDTH-1:0] sr_nxt;
   logic [CW-1:0]    cnt;
   logic             frame;
   logic             wrap;

   assign sr_nxt = {sr[WIDTH-2:0], DS};
   assign wrap   = SH_EN && (cnt == LAST);

   always_ff @(posedge CP or posedge RD) begin
      if (RD) begin
         sr    <= '0;
         str   <= '0;
         cnt   <= '0;
         frame <= 1'b0;
      end else begin
         frame <= wrap;
         if (SH_EN) begin
            sr  <= sr_nxt;
            cnt <= wrap ? '0 : cnt + CW'(1);
         end
         // Auto-latch captures the completed frame and wins over a coincident strobe.
         if (AUTO_LATCH && wrap)
            str <= sr_nxt;
         else if (ST_EN)
            str <= sr;
      end
   end

   assign Q     = OE_N ? {WIDTH{1'bz}} : str;
   assign QS    = sr[WIDTH-1];
   assign CNT   = cnt;
   assign FRAME = frame;

endmodule
